spi_receptor: RTL and testbench

SPI_RECEPTOR -- requirements
Module: spi_receptor

---
 rtl/spi_receptor.sv | 163 ++++++++++++++++
 tb/tb_spi_receptor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_receptor.sv
// spi_receptor: SPI slave. SCK, SS and MOSI are synchronized into CLK, and the
// SPI edges are found by comparing each synchronized input with its previous
// sample. A frame is 16 bits, MSB first, in any of the four CKP/CPH modes.
module spi_receptor (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CKP,
    input  logic        CPH,
    input  logic        SCK,
    input  logic        SS,
    input  logic        MOSI,
    input  logic [15:0] TX_DATA,
    output logic        MISO,
    output logic [15:0] RX_DATA,
    output logic        RX_VALID,
    output logic        BUSY
);
    localparam int unsigned W  = 16;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

    logic          ss_meta_q, ss_sync_q, ss_prev_q;
    logic          sck_meta_q, sck_sync_q, sck_prev_q;
    logic          mosi_meta_q, mosi_sync_q;
    logic [1:0]    settle_q;
    logic          armed_q;
    state_t        state_q;
    logic          ckp_q, cph_q;
    logic [W-1:0]  tx_sr_q, rx_sr_q, rx_data_q;
    logic [CW-1:0] cnt_q;
    logic          miso_q, rx_valid_q, busy_q;

    logic ss_fall_c, ss_rise_c, sck_rise_c, sck_fall_c;
    logic lead_c, trail_c, sample_c, shift_c;

    // Two-flop synchronizers plus one previous-sample flop for edge detection
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_prev_q   <= 1'b1;
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            ss_meta_q   <= SS;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            sck_meta_q  <= SCK;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            mosi_meta_q <= MOSI;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // Arm frame starts only once SS has been seen high after the synchronizer
    // has flushed its reset value; a low SS held through reset cannot start a frame
    always_ff @(posedge CLK) begin
        if (RESET) begin
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != 2'd2) begin
                settle_q <= settle_q + 2'd1;
            end
            if (settle_q == 2'd2 && ss_sync_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign ss_fall_c  = ss_prev_q & ~ss_sync_q;
    assign ss_rise_c  = ~ss_prev_q & ss_sync_q;
    assign sck_rise_c = sck_sync_q & ~sck_prev_q;
    assign sck_fall_c = ~sck_sync_q & sck_prev_q;
    assign lead_c     = ckp_q ? sck_fall_c : sck_rise_c;
    assign trail_c    = ckp_q ? sck_rise_c : sck_fall_c;
    assign sample_c   = cph_q ? trail_c : lead_c;
    assign shift_c    = cph_q ? lead_c : trail_c;

    // Frame FSM: shift registers, bit counter and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            ckp_q      <= 1'b0;
            cph_q      <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            cnt_q      <= '0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (ss_fall_c && armed_q) begin
                        state_q <= XFER;
                        busy_q  <= 1'b1;
                        ckp_q   <= CKP;
                        cph_q   <= CPH;
                        cnt_q   <= '0;
                        rx_sr_q <= '0;
                        if (CPH) begin
                            tx_sr_q <= TX_DATA;
                        end else begin
                            tx_sr_q <= {TX_DATA[W-2:0], 1'b0};
                            miso_q  <= TX_DATA[W-1];
                        end
                    end
                end
                XFER: begin
                    if (ss_rise_c) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        miso_q  <= 1'b0;
                        cnt_q   <= '0;
                        rx_sr_q <= '0;
                        tx_sr_q <= '0;
                    end else begin
                        if (shift_c) begin
                            miso_q  <= tx_sr_q[W-1];
                            tx_sr_q <= {tx_sr_q[W-2:0], 1'b0};
                        end
                        if (sample_c) begin
                            rx_sr_q <= {rx_sr_q[W-2:0], mosi_sync_q};
                            cnt_q   <= cnt_q + CW'(1);
                            if (cnt_q == CW'(W - 1)) begin
                                rx_data_q  <= {rx_sr_q[W-2:0], mosi_sync_q};
                                rx_valid_q <= 1'b1;
                                miso_q     <= 1'b0;
                                state_q    <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    miso_q <= 1'b0;
                    if (ss_sync_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign MISO     = miso_q;
    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_spi_receptor.sv
// tb_spi_receptor: directed SPI master driving spi_receptor in all four modes,
// plus abort, mid-frame reset, back-to-back frames and ignored extra edges.
module tb_spi_receptor;
    localparam int HALF = 5;

    logic        CLK = 1'b0;
    logic        RESET, CKP, CPH, SCK, SS, MOSI;
    logic [15:0] TX_DATA;
    logic        MISO;
    logic [15:0] RX_DATA;
    logic        RX_VALID;
    logic        BUSY;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          vcount = 0;
    logic [15:0] vdata  = 16'h0;

    spi_receptor dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CKP      (CKP),
        .CPH      (CPH),
        .SCK      (SCK),
        .SS       (SS),
        .MOSI     (MOSI),
        .TX_DATA  (TX_DATA),
        .MISO     (MISO),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    // Count RX_VALID pulses and remember the word delivered with each
    always @(negedge CLK) begin
        if (RX_VALID) begin
            vcount <= vcount + 1;
            vdata  <= RX_DATA;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_clk(input int n);
        for (int k = 0; k < n; k++) @(negedge CLK);
    endtask

    // One SPI master frame; rst_bit/flip_bit < 0 disables those events
    task automatic spi_frame(input logic ckp, input logic cph, input logic [15:0] tx,
                             input logic [15:0] mosi_w, input int nbits, input int rst_bit,
                             input int flip_bit, input int extra, output logic [15:0] miso_w);
        logic [15:0] sh;
        logic [15:0] got;
        sh  = mosi_w;
        got = 16'h0;
        CKP = ckp;
        CPH = cph;
        TX_DATA = tx;
        SCK = ckp;
        wait_clk(2);
        SS = 1'b0;
        if (!cph) begin
            MOSI = sh[15];
            sh   = {sh[14:0], 1'b0};
        end
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                RESET = 1'b1;
                wait_clk(1);
                RESET = 1'b0;
                chk("rst_rx_data", 32'(RX_DATA), 32'h0);
                chk("rst_busy", 32'(BUSY), 32'h0);
                chk("rst_miso", 32'(MISO), 32'h0);
                chk("rst_rx_valid", 32'(RX_VALID), 32'h0);
            end
            if (i == flip_bit) CKP = ~CKP;
            if (i == 8 && rst_bit < 0) chk("busy_mid", 32'(BUSY), 32'h1);
            if (!cph) got = {got[14:0], MISO};
            SCK = ~SCK;
            if (cph) begin
                MOSI = sh[15];
                sh   = {sh[14:0], 1'b0};
            end
            wait_clk(HALF);
            if (cph) got = {got[14:0], MISO};
            SCK = ~SCK;
            if (!cph && i < 15) begin
                MOSI = sh[15];
                sh   = {sh[14:0], 1'b0};
            end
            wait_clk(HALF);
        end
        for (int e = 0; e < extra; e++) begin
            SCK = ~SCK;
            wait_clk(HALF);
            chk("extra_miso", 32'(MISO), 32'h0);
            SCK = ~SCK;
            wait_clk(HALF);
        end
        if (rst_bit >= 0) chk("rst_no_restart", 32'(BUSY), 32'h0);
        SS   = 1'b1;
        MOSI = 1'b0;
        wait_clk(3);
        chk("busy_off", 32'(BUSY), 32'h0);
        wait_clk(3);
        miso_w = got;
    endtask

    task automatic check_frame(input string tag, input int v0, input logic [15:0] exp_rx,
                               input logic [15:0] got_miso, input logic [15:0] exp_miso);
        chk({tag, "_valid_cnt"}, 32'(vcount - v0), 32'h1);
        chk({tag, "_valid_data"}, 32'(vdata), 32'(exp_rx));
        chk({tag, "_rx_data"}, 32'(RX_DATA), 32'(exp_rx));
        chk({tag, "_miso"}, 32'(got_miso), 32'(exp_miso));
    endtask

    initial begin
        logic [15:0] mw;
        int          v0;
        RESET = 1'b1; SS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        CKP = 1'b0; CPH = 1'b0; TX_DATA = 16'h0;
        wait_clk(3);
        RESET = 1'b0;
        wait_clk(4);
        chk("reset_rx_data", 32'(RX_DATA), 32'h0);
        chk("reset_rx_valid", 32'(RX_VALID), 32'h0);
        chk("reset_busy", 32'(BUSY), 32'h0);
        chk("reset_miso", 32'(MISO), 32'h0);

        // Four SPI modes
        v0 = vcount;
        spi_frame(1'b0, 1'b0, 16'hA5C3, 16'h1234, 16, -1, -1, 0, mw);
        check_frame("m00", v0, 16'h1234, mw, 16'hA5C3);
        v0 = vcount;
        spi_frame(1'b0, 1'b1, 16'h3C96, 16'hBEEF, 16, -1, -1, 0, mw);
        check_frame("m01", v0, 16'hBEEF, mw, 16'h3C96);
        v0 = vcount;
        spi_frame(1'b1, 1'b0, 16'h5AA5, 16'h0F0F, 16, -1, -1, 0, mw);
        check_frame("m10", v0, 16'h0F0F, mw, 16'h5AA5);
        v0 = vcount;
        spi_frame(1'b1, 1'b1, 16'h8001, 16'hFFFF, 16, -1, -1, 0, mw);
        check_frame("m11", v0, 16'hFFFF, mw, 16'h8001);

        // Abort after 9 bits keeps the previous word
        v0 = vcount;
        spi_frame(1'b0, 1'b0, 16'h0000, 16'hCAFE, 9, -1, -1, 0, mw);
        chk("abort_valid_cnt", 32'(vcount - v0), 32'h0);
        chk("abort_rx_data", 32'(RX_DATA), 32'hFFFF);

        // Reset at bit 7 with SS held low, then a clean frame
        v0 = vcount;
        spi_frame(1'b0, 1'b0, 16'h0000, 16'h1357, 16, 7, -1, 0, mw);
        chk("rstf_valid_cnt", 32'(vcount - v0), 32'h0);
        chk("rstf_rx_data", 32'(RX_DATA), 32'h0);
        v0 = vcount;
        spi_frame(1'b1, 1'b1, 16'h7E81, 16'h2468, 16, -1, -1, 0, mw);
        check_frame("after_rst", v0, 16'h2468, mw, 16'h7E81);

        // Back-to-back frames
        v0 = vcount;
        spi_frame(1'b0, 1'b0, 16'h00FF, 16'h0001, 16, -1, -1, 0, mw);
        check_frame("b2b_a", v0, 16'h0001, mw, 16'h00FF);
        v0 = vcount;
        spi_frame(1'b0, 1'b0, 16'hFF00, 16'h8000, 16, -1, -1, 0, mw);
        check_frame("b2b_b", v0, 16'h8000, mw, 16'hFF00);

        // CKP toggled mid-frame and extra SCK edges after the last bit
        v0 = vcount;
        spi_frame(1'b0, 1'b0, 16'h9876, 16'h6789, 16, -1, 8, 2, mw);
        check_frame("extra", v0, 16'h6789, mw, 16'h9876);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
